// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the instruction-fetch stage
package pipe_pkg;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef logic [0:0] state_t;
    localparam state_t ST_FETCH = 1'b0;
    localparam state_t ST_HOLD  = 1'b1;

endpackage

// File: rtl/mux4x32.sv
// rtl/mux4x32.sv - 4-way 32-bit selector
module mux4x32 (
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [1:0]  s,
    output logic [31:0] y
);

    always_comb begin
        y = a0;
        case (s)
            2'b00: y = a0;
            2'b01: y = a1;
            2'b10: y = a2;
            2'b11: y = a3;
            default: y = a0;
        endcase
    end

endmodule

// File: rtl/pipeif.sv
// rtl/pipeif.sv - fetch stage: PC, imem handshake, fetch buffer, redirect latch, IF/ID register
module pipeif
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] da,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst
);

    state_t      state;
    logic        buf_valid;
    logic [31:0] buf_inst;
    logic        redir_valid;
    logic [31:0] redir_pc;

    logic [31:0] pc4;
    logic [31:0] target;
    logic        ack;
    logic        avail;
    logic [31:0] word;
    logic        redir_take;

    assign pc4        = pc + 32'd4;
    // Held low during reset so the first request appears in the first cycle after release.
    assign imem_req   = resetn & (state == ST_FETCH);
    assign imem_addr  = pc;
    assign ack        = imem_req & imem_ack;
    assign avail      = ack | buf_valid;
    assign word       = buf_valid ? buf_inst : imem_rdata;
    assign redir_take = wpcir & (pcsource != PCSRC_PC4) & ~redir_valid;

    mux4x32 u_npc_mux (
        .a0 (pc4),
        .a1 (bpc),
        .a2 (da),
        .a3 (jpc),
        .s  (pcsource),
        .y  (target)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            dpc4        <= 32'h0;
            inst        <= NOP_INST;
            buf_valid   <= 1'b0;
            buf_inst    <= 32'h0;
            redir_valid <= 1'b0;
            redir_pc    <= 32'h0;
        end else begin
            case (state)
                ST_FETCH: if (ack && !wpcir) state <= ST_HOLD;
                ST_HOLD:  if (wpcir)         state <= ST_FETCH;
                default:                     state <= ST_FETCH;
            endcase

            if (wpcir) begin
                if (avail) begin
                    inst        <= word;
                    dpc4        <= pc4;
                    buf_valid   <= 1'b0;
                    redir_valid <= 1'b0;
                    if (redir_valid)
                        pc <= redir_pc;
                    else if (redir_take)
                        pc <= target;
                    else
                        pc <= pc4;
                end else begin
                    // Delay slot not yet fetched: remember the target until it arrives.
                    inst <= NOP_INST;
                    if (redir_take) begin
                        redir_valid <= 1'b1;
                        redir_pc    <= target;
                    end
                end
            end else if (ack) begin
                buf_valid <= 1'b1;
                buf_inst  <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_pipeif.sv
// tb/tb_pipeif.sv - directed self-checking bench for pipeif
module tb_pipeif;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] da;
    logic        wpcir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] inst;

    int tests;
    int fails;

    pipeif #(.RESET_PC(32'h0000_0000)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .da         (da),
        .wpcir      (wpcir),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst)
    );

    // Memory contents: word at address a is {16'hC0DE, a[15:0]}.
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        resetn   = 1'b0;
        pcsource = 2'b00;
        bpc      = 32'h0;
        jpc      = 32'h0;
        da       = 32'h0;
        wpcir    = 1'b1;
        imem_ack = 1'b1;

        step();
        step();
        check("rst_pc",   pc,       32'h0);
        check("rst_dpc4", dpc4,     32'h0);
        check("rst_inst", inst,     32'h0);
        check("rst_req",  {31'b0, imem_req}, 32'h0);

        resetn = 1'b1;
        #1;
        check("req0",  {31'b0, imem_req}, 32'h1);
        check("addr0", imem_addr, 32'h0);

        // zero-wait sequential fetch
        step();
        check("seq0_inst", inst, 32'hC0DE_0000);
        check("seq0_dpc4", dpc4, 32'h4);
        check("seq0_pc",   pc,   32'h4);
        step();
        check("seq1_inst", inst, 32'hC0DE_0004);
        check("seq1_dpc4", dpc4, 32'h8);

        // two wait cycles at pc=8
        imem_ack = 1'b0;
        step();
        check("w1_inst", inst, 32'h0);
        check("w1_dpc4", dpc4, 32'h8);
        check("w1_addr", imem_addr, 32'h8);
        step();
        check("w2_inst", inst, 32'h0);
        check("w2_pc",   pc,   32'h8);
        imem_ack = 1'b1;
        step();
        check("w3_inst", inst, 32'hC0DE_0008);
        check("w3_dpc4", dpc4, 32'hC);
        step();
        step();
        check("pre_br_pc", pc, 32'h14);

        // branch with delay slot acked the same cycle
        pcsource = 2'b01;
        bpc      = 32'h40;
        step();
        check("br_inst", inst, 32'hC0DE_0014);
        check("br_dpc4", dpc4, 32'h18);
        check("br_pc",   pc,   32'h40);
        pcsource = 2'b00;
        step();
        check("br_tgt_inst", inst, 32'hC0DE_0040);
        check("br_tgt_pc",   pc,   32'h44);

        // branch with delay slot acked three cycles late
        pcsource = 2'b01;
        bpc      = 32'h80;
        imem_ack = 1'b0;
        step();
        check("lb1_inst", inst, 32'h0);
        check("lb1_pc",   pc,   32'h44);
        pcsource = 2'b11;
        jpc      = 32'h200;
        step();
        check("lb2_inst", inst, 32'h0);
        step();
        check("lb3_pc",   pc,   32'h44);
        pcsource = 2'b00;
        imem_ack = 1'b1;
        step();
        check("lb4_inst", inst, 32'hC0DE_0044);
        check("lb4_dpc4", dpc4, 32'h48);
        check("lb4_pc",   pc,   32'h80);

        // two-cycle stall, ack in the first
        wpcir = 1'b0;
        check("st0_req", {31'b0, imem_req}, 32'h1);
        step();
        check("st1_req",  {31'b0, imem_req}, 32'h0);
        check("st1_inst", inst, 32'hC0DE_0044);
        check("st1_pc",   pc,   32'h80);
        step();
        check("st2_inst", inst, 32'hC0DE_0044);
        check("st2_dpc4", dpc4, 32'h48);
        wpcir = 1'b1;
        #1;
        check("rel_req", {31'b0, imem_req}, 32'h0);
        step();
        check("rel_inst", inst, 32'hC0DE_0080);
        check("rel_dpc4", dpc4, 32'h84);
        check("rel_pc",   pc,   32'h84);
        check("rel_req2", {31'b0, imem_req}, 32'h1);

        // jr to 0x20, then reset mid-request
        pcsource = 2'b10;
        da       = 32'h20;
        step();
        check("jr_pc", pc, 32'h20);
        pcsource = 2'b00;
        imem_ack = 1'b0;
        step();
        check("mid_addr", imem_addr, 32'h20);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_pc",   pc,   32'h0);
        check("arst_inst", inst, 32'h0);
        check("arst_dpc4", dpc4, 32'h0);
        check("arst_req",  {31'b0, imem_req}, 32'h0);
        step();
        resetn   = 1'b1;
        imem_ack = 1'b1;
        step();
        check("post_rst_inst", inst, 32'hC0DE_0000);

        // wrap from 0xFFFF_FFFC
        pcsource = 2'b11;
        jpc      = 32'hFFFF_FFFC;
        step();
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        pcsource = 2'b00;
        step();
        check("wrap_inst", inst, 32'hC0DE_FFFC);
        check("wrap_dpc4", dpc4, 32'h0);
        check("wrap_pc",   pc,   32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeif.md
# pipeif

Instruction-fetch stage of the five-stage pipelined CPU: owns the PC, issues word requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register (`dpc4`, `inst`) consumed by the decode stage. It takes next-PC selection (`pcsource`, `bpc`, `jpc`, `da`) and the stall signal `wpcir` back from decode. Branches and jumps use delay-slot semantics. Slow memory is absorbed with bubbles, a one-entry fetch buffer and a latched redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC value after reset.
- `clock`  in  1  system clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `pcsource`  in  2  from decode: 00 pc+4, 01 `bpc`, 10 `da` (jr), 11 `jpc`
- `bpc`  in  32  branch target
- `jpc`  in  32  jump target
- `da`  in  32  register jump target
- `wpcir`  in  1  1 = PC and IF/ID may update; 0 = stall (hold)
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  word address (= `pc`)
- `imem_ack`  in  1  read data valid this cycle; meaningful only while `imem_req`=1
- `imem_rdata`  in  32  instruction word
- `pc`  out  32  current fetch PC (observation)
- `dpc4`  out  32  IF/ID: fetched PC + 4
- `inst`  out  32  IF/ID: instruction (32'h0 = NOP/bubble)

## Operation
- `avail` = (`imem_req` & `imem_ack`) | `buf_valid`; `word` = `buf_valid` ? `buf_inst` : `imem_rdata`.
- Only one request is outstanding. `imem_addr` stays stable while `imem_req`=1 until ack. `imem_req`=1 whenever `buf_valid`=0. An ack may arrive in the same cycle as the request.
- Redirect accepted only when `wpcir`=1, `pcsource`!=00 and `redir_valid`=0. Target is selected by `pcsource`. At that moment IF is fetching the delay slot.
- Each cycle with `wpcir`=1:
  - `avail`: `inst`<=`word`, `dpc4`<=`pc`+4, `buf_valid`<=0.
  - `pc` <= `redir_pc` if `redir_valid`; else the accepted redirect target; else `pc`+4.
  - `redir_valid`<=0.
  - !`avail`: `inst`<=0 (bubble), `dpc4` holds, `pc` holds. An accepted redirect sets `redir_valid`<=1 and `redir_pc`<=target.
- Cycle with `wpcir`=0: `pc`, `dpc4`, `inst` and `redir_*` hold. `pcsource` is ignored. If an ack arrives: `buf_valid`<=1, `buf_inst`<=`imem_rdata`, and `imem_req` drops next cycle.
- While `redir_valid`=1, decode holds bubbles, so `pcsource` is ignored.
- FSM has two states:
  - FETCH (req high): ack & !`wpcir` → HOLD; otherwise stay.
  - HOLD (buffer full, req low): `wpcir` → FETCH.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0. No alignment check; low two bits pass through.

## Timing
- Reset (async, immediate) sets:
  - `pc`=`RESET_PC`, `dpc4`=0, `inst`=0
  - `buf_valid`=0, `redir_valid`=0, `redir_pc`=0
  - state FETCH, `imem_req`=0
- First request goes out in the first cycle after `resetn` rises. Memory must tolerate `imem_req` dropping mid-request on reset.
- Latency with a zero-wait memory: request in cycle t, word in `inst` after edge t. One instruction per cycle.
- Each memory wait cycle inserts exactly one bubble.
- Simultaneous redirect and ack: ack completes the delay slot and `pc` takes the target directly; no latch.
- Ack during stall: the word is delivered on the first cycle `wpcir`=1, with no new request that cycle.

## Structure
- Shared package `pipe_pkg`:
  - `PCSRC_PC4`/`PCSRC_BR`/`PCSRC_JR`/`PCSRC_J` encodings
  - `NOP_INST`=32'h0
  - FSM state typedef
- The next-PC target select reuses existing `mux4x32`.
- Everything else stays in `pipeif`: PC register, IF/ID register, buffer, redirect latch.

## Test plan
- Zero-wait memory, sequential code from 0: `inst` gets words at 0, 4, 8; `dpc4`=4, 8, 12; no bubbles.
- Ack withheld 2 cycles at pc=8: two `inst`=0 bubbles, `dpc4` holds 8, then word@8 with `dpc4`=12.
- Branch in ID (`pcsource`=01, `bpc`=0x40) with delay slot pc=0x14 acked same cycle: next `inst`=word@0x14, `pc`=0x40.
- Same branch, delay-slot ack 3 cycles late: `redir_valid` set, bubbles inserted, then word@0x14, `pc`=0x40. A `pcsource`=11 during the wait is ignored.
- `wpcir`=0 for 2 cycles with ack in the first: `imem_req` low in the second cycle, IF/ID holds. On release the buffered word enters `inst` and `pc` advances by 4.
- `resetn` pulsed low mid-request at `pc`=0x20: outputs are immediately at reset values. `pc` wrap check: from 0xFFFF_FFFC the next `pc`=0.
